// File: rtl/ssd_pkg.sv
// Shared constants and types for the seven-segment scan controller.
// Segment polarity is active-low, ordered {g,f,e,d,c,b,a}.
package ssd_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_BLANK,
    PH_DRIVE
  } phase_e;

  function automatic int cw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ssd.sv
// Hex nibble to active-low seven-segment pattern, {g,f,e,d,c,b,a}.
// Purely combinational; shared by every digit of the scan.
module ssd
  import ssd_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_BLANK;
    unique case (hex)
      4'h0: seg_n = 7'b1000000;
      4'h1: seg_n = 7'b1111001;
      4'h2: seg_n = 7'b0100100;
      4'h3: seg_n = 7'b0110000;
      4'h4: seg_n = 7'b0011001;
      4'h5: seg_n = 7'b0010010;
      4'h6: seg_n = 7'b0000010;
      4'h7: seg_n = 7'b1111000;
      4'h8: seg_n = 7'b0000000;
      4'h9: seg_n = 7'b0010000;
      4'hA: seg_n = 7'b0001000;
      4'hB: seg_n = 7'b0000011;
      4'hC: seg_n = 7'b1000110;
      4'hD: seg_n = 7'b0100001;
      4'hE: seg_n = 7'b0000110;
      4'hF: seg_n = 7'b0001110;
    endcase
  end

endmodule

// File: rtl/ssd_slot_timer.sv
// Slot counter and digit index for the scan; exports next-state phase
// and index so the outputs can be registered with no extra latency.
module ssd_slot_timer
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIV        = 1000,
  parameter int BLANK      = 4,
  parameter int IW         = cw(NUM_DIGITS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output phase_e        phase_nxt,
  output logic [IW-1:0] idx_nxt,
  output logic          slot_end,
  output logic          frame_end
);

  localparam int CW = cw(DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_BLK = CW'(BLANK);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

  phase_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PH_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d   = PH_IDLE;
    cnt_d     = '0;
    idx_d     = '0;
    slot_end  = 1'b0;
    frame_end = 1'b0;
    if (en) begin
      // leaving IDLE restarts at digit 0, count 0
      if (state_q != PH_IDLE) begin
        slot_end  = (cnt_q == CNT_MAX);
        frame_end = slot_end && (idx_q == IDX_MAX);
        if (slot_end) begin
          idx_d = frame_end ? '0 : idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          idx_d = idx_q;
        end
      end
      state_d = (cnt_d < CNT_BLK) ? PH_BLANK : PH_DRIVE;
    end
    phase_nxt = state_d;
    idx_nxt   = idx_d;
  end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Multiplexed common-anode display scanner with double-buffered
// digit values; shadow contents go live only at frame boundaries.
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIV        = 1000,
  parameter int BLANK      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  output logic                    load_ack,
  output logic [NUM_DIGITS-1:0]   dig_n,
  output logic [6:0]              seg_n,
  output logic                    frame_done
);

  localparam int IW = cw(NUM_DIGITS);
  localparam int VW = 4 * NUM_DIGITS;

  logic [VW-1:0]         shd_val_q, shd_val_d;
  logic [VW-1:0]         act_val_q, act_val_d;
  logic [NUM_DIGITS-1:0] shd_msk_q, shd_msk_d;
  logic [NUM_DIGITS-1:0] act_msk_q, act_msk_d;
  logic                  pending_q, pending_d;
  logic                  load_ack_q, load_ack_d;
  logic                  frame_done_q, frame_done_d;
  logic [NUM_DIGITS-1:0] dig_n_q, dig_n_d;
  logic [6:0]            seg_n_q, seg_n_d;

  phase_e        phase_nxt;
  logic [IW-1:0] idx_nxt;
  logic          slot_end;
  logic          frame_end;
  logic          copy;
  logic [3:0]    nib;
  logic          nib_off;
  logic [6:0]    dec_seg;

  ssd_slot_timer #(
    .NUM_DIGITS(NUM_DIGITS),
    .DIV       (DIV),
    .BLANK     (BLANK),
    .IW        (IW)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .phase_nxt(phase_nxt),
    .idx_nxt  (idx_nxt),
    .slot_end (slot_end),
    .frame_end(frame_end)
  );

  ssd u_dec (
    .hex  (nib),
    .seg_n(dec_seg)
  );

  always_comb begin
    shd_val_d    = shd_val_q;
    shd_msk_d    = shd_msk_q;
    act_val_d    = act_val_q;
    act_msk_d    = act_msk_q;
    pending_d    = pending_q;
    load_ack_d   = 1'b0;
    frame_done_d = frame_end;
    copy         = pending_q && (en ? frame_end : 1'b1);
    if (copy) begin
      act_val_d  = shd_val_q;
      act_msk_d  = shd_msk_q;
      pending_d  = 1'b0;
      load_ack_d = 1'b1;
    end
    // a load on the copy edge stays pending for the next boundary
    if (load) begin
      shd_val_d = value;
      shd_msk_d = blank_mask;
      pending_d = 1'b1;
    end
  end

  always_comb begin
    nib     = '0;
    nib_off = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IW'(i) == idx_nxt) begin
        nib     = act_val_d[4*i +: 4];
        nib_off = act_msk_d[i];
      end
    end
    dig_n_d = '1;
    seg_n_d = SEG_BLANK;
    if ((phase_nxt == PH_DRIVE) && !nib_off) begin
      dig_n_d = ~(NUM_DIGITS'(1) << idx_nxt);
      seg_n_d = dec_seg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shd_val_q    <= '0;
      shd_msk_q    <= '0;
      act_val_q    <= '0;
      act_msk_q    <= '0;
      pending_q    <= 1'b0;
      load_ack_q   <= 1'b0;
      frame_done_q <= 1'b0;
      dig_n_q      <= '1;
      seg_n_q      <= SEG_BLANK;
    end else begin
      shd_val_q    <= shd_val_d;
      shd_msk_q    <= shd_msk_d;
      act_val_q    <= act_val_d;
      act_msk_q    <= act_msk_d;
      pending_q    <= pending_d;
      load_ack_q   <= load_ack_d;
      frame_done_q <= frame_done_d;
      dig_n_q      <= dig_n_d;
      seg_n_q      <= seg_n_d;
    end
  end

  assign load_ack   = load_ack_q;
  assign frame_done = frame_done_q;
  assign dig_n      = dig_n_q;
  assign seg_n      = seg_n_q;

endmodule
